// File: rtl/seq_divider.sv
// Sequential 4-bit by 2-bit unsigned divider, restoring shift-subtract, one quotient
// bit per clock, MSB first. A zero divisor completes immediately with quotient all ones.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] dividend,
    input  logic [1:0] divisor,
    output logic [3:0] quotient,
    output logic [1:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       dz
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    logic [3:0] dvd_r;
    logic [1:0] dvs_r;
    logic [2:0] p;
    logic [3:0] q_work;
    logic [1:0] cnt;

    logic [1:0] bit_idx;
    logic [2:0] p_shift;
    logic [2:0] p_next;
    logic       q_bit;

    // One restoring step: shift in the next dividend bit, subtract when it fits.
    always_comb begin
        bit_idx = ~cnt;
        p_shift = {p[1:0], dvd_r[bit_idx]};
        p_next  = p_shift;
        q_bit   = 1'b0;
        if (p_shift >= {1'b0, dvs_r}) begin
            p_next = p_shift - {1'b0, dvs_r};
            q_bit  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd_r     <= 4'd0;
            dvs_r     <= 2'd0;
            p         <= 3'd0;
            q_work    <= 4'd0;
            cnt       <= 2'd0;
            quotient  <= 4'd0;
            remainder <= 2'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            dz        <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        dvd_r  <= dividend;
                        dvs_r  <= divisor;
                        p      <= 3'd0;
                        q_work <= 4'd0;
                        cnt    <= 2'd0;
                        if (divisor == 2'd0) begin
                            // No iteration: the result is defined, not computed.
                            state     <= DONE;
                            quotient  <= 4'b1111;
                            remainder <= dividend[1:0];
                            dz        <= 1'b1;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                        end else begin
                            state <= RUN;
                            dz    <= 1'b0;
                            done  <= 1'b0;
                            busy  <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    p      <= p_next;
                    q_work <= {q_work[2:0], q_bit};
                    cnt    <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        // Outputs update only here, so partial values stay hidden.
                        quotient  <= {q_work[2:0], q_bit};
                        remainder <= p_next[1:0];
                        state     <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: named vectors, held-start and reset-abort cases,
// and a sweep of all 64 operand pairs against arithmetic expectations.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] dividend;
    logic [1:0] divisor;
    logic [3:0] quotient;
    logic [1:0] remainder;
    logic       busy;
    logic       done;
    logic       dz;

    int checks = 0;
    int errors = 0;
    logic [3:0] prev_q;
    logic [1:0] prev_r;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .quotient (quotient),
        .remainder(remainder),
        .busy     (busy),
        .done     (done),
        .dz       (dz)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // While iterating, the previous result must still be on the outputs.
    task automatic check_running(input string tag);
        check({tag, " busy"}, {7'd0, busy}, 8'd1);
        check({tag, " done"}, {7'd0, done}, 8'd0);
        check({tag, " dz"}, {7'd0, dz}, 8'd0);
        check({tag, " q hold"}, {4'd0, quotient}, {4'd0, prev_q});
        check({tag, " r hold"}, {6'd0, remainder}, {6'd0, prev_r});
    endtask

    task automatic check_result(input string tag, input logic [3:0] dd, input logic [1:0] dv);
        logic [3:0] eq;
        logic [1:0] er;
        if (dv == 2'd0) begin
            eq = 4'b1111;
            er = dd[1:0];
        end else begin
            eq = dd / {2'd0, dv};
            er = 2'(dd % {2'd0, dv});
        end
        check({tag, " done"}, {7'd0, done}, 8'd1);
        check({tag, " busy"}, {7'd0, busy}, 8'd0);
        check({tag, " dz"}, {7'd0, dz}, {7'd0, (dv == 2'd0)});
        check({tag, " quotient"}, {4'd0, quotient}, {4'd0, eq});
        check({tag, " remainder"}, {6'd0, remainder}, {6'd0, er});
        prev_q = eq;
        prev_r = er;
    endtask

    // Pulse start for one edge, then follow the operation to completion.
    task automatic run_div(input string tag, input logic [3:0] dd, input logic [1:0] dv);
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (dv != 2'd0) begin
            check_running({tag, " run0"});
            repeat (3) begin
                @(negedge clk);
                check_running({tag, " run"});
            end
            @(negedge clk);
        end
        check_result(tag, dd, dv);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " quotient"}, {4'd0, quotient}, 8'd0);
        check({tag, " remainder"}, {6'd0, remainder}, 8'd0);
        check({tag, " busy"}, {7'd0, busy}, 8'd0);
        check({tag, " done"}, {7'd0, done}, 8'd0);
        check({tag, " dz"}, {7'd0, dz}, 8'd0);
        prev_q = 4'd0;
        prev_r = 2'd0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b1;
        dividend = 4'd13;
        divisor  = 2'd3;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst   = 1'b0;
        start = 1'b0;

        run_div("13/3", 4'd13, 2'd3);
        run_div("15/1", 4'd15, 2'd1);
        run_div("2/3", 4'd2, 2'd3);
        run_div("9/0", 4'd9, 2'd0);

        // New operands and start held high throughout the 13/3 run.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        dividend = 4'd6;
        divisor  = 2'd2;
        check_running("ign run0");
        repeat (3) begin
            @(negedge clk);
            check_running("ign run");
        end
        @(negedge clk);
        check_result("ign 13/3", 4'd13, 2'd3);
        // start is still high in DONE, so 6/2 is taken at the next edge.
        @(negedge clk);
        start = 1'b0;
        check_running("b2b run0");
        repeat (3) begin
            @(negedge clk);
            check_running("b2b run");
        end
        @(negedge clk);
        check_result("b2b 6/2", 4'd6, 2'd2);

        // Reset during the second RUN cycle of 13/3.
        @(negedge clk);
        dividend = 4'd13;
        divisor  = 2'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check_running("abort run0");
        @(negedge clk);
        check_running("abort run1");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_reset_state("abort");
        run_div("10/3", 4'd10, 2'd3);

        for (int dd = 0; dd < 16; dd++) begin
            for (int dv = 0; dv < 4; dv++) begin
                run_div($sformatf("sweep %0d/%0d", dd, dv), 4'(dd), 2'(dv));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Busy and done are mutually exclusive on every cycle.
    always @(negedge clk) begin
        if (!rst && busy && done) begin
            errors++;
            $display("FAIL busy_done_overlap busy %0d done %0d required not both", busy, done);
        end
    end

endmodule

// File: doc/seq_divider.md
SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port start, input, 1 bit: request to begin a division.
REQ-005 The block SHALL have port dividend, input, 4 bits: unsigned dividend, same width as the 2x2 multiplier product.
REQ-006 The block SHALL have port divisor, input, 2 bits: unsigned divisor.
REQ-007 The block SHALL have port quotient, output, 4 bits: registered unsigned quotient.
REQ-008 The block SHALL have port remainder, output, 2 bits: registered unsigned remainder.
REQ-009 The block SHALL have port busy, output, 1 bit: high while a division is iterating.
REQ-010 The block SHALL have port done, output, 1 bit: high while results are valid.
REQ-011 The block SHALL have port dz, output, 1 bit: divide-by-zero flag for the current result.

Function
REQ-012 The block SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-013 IDLE or DONE with start=1 at a rising edge SHALL perform the following:
- capture dividend and divisor into internal registers;
- clear done and dz;
- enter RUN, or enter DONE directly if divisor=0 (see REQ-018).
REQ-014 start SHALL be ignored in RUN, and captured operands SHALL remain unaffected by input changes during RUN.
REQ-015 RUN SHALL last exactly 4 cycles, producing one quotient bit per cycle using restoring shift-subtract, MSB first:
- partial remainder P is 3 bits wide and starts at 0;
- each step: P = {P[1:0], dividend bit i}, for i = 3 down to 0;
- if P >= divisor, then P = P - divisor and quotient bit i = 1; otherwise quotient bit i = 0.
REQ-016 On the 4th RUN edge, the block SHALL perform the following:
- load quotient and remainder = P[1:0];
- set done=1;
- enter DONE.
Results are therefore valid 4 rising edges after the edge that accepted start.
REQ-017 busy SHALL be 1 in RUN only, done SHALL be 1 in DONE only, and busy and done SHALL never both be 1.
REQ-018 If divisor=0 at acceptance, the block SHALL perform the following on the next edge:
- enter DONE;
- set quotient=4'b1111, remainder=dividend[1:0], dz=1 and done=1;
- never assert busy.
REQ-019 quotient, remainder and dz SHALL hold their values in DONE until the next accepted start or reset.
REQ-020 In DONE, start=1 SHALL behave exactly as start in IDLE (back-to-back operation with no idle cycle).
REQ-021 quotient and remainder SHALL change only at completion edges; intermediate iteration values SHALL never be visible on the outputs.
REQ-022 Invariant for a completed non-zero division: quotient*divisor + remainder = dividend and remainder < divisor.

Reset
REQ-023 rst=1 at a rising edge SHALL force the following, overriding start:
- state IDLE;
- quotient=0, remainder=0;
- busy=0, done=0, dz=0;
- internal P and iteration counter = 0.
REQ-024 rst SHALL abort an in-progress RUN with no partial result appearing on the outputs.
REQ-025 After rst deasserts, the block SHALL accept start on the first following edge.

Verification
REQ-026 The bench SHALL cover: dividend=13, divisor=3, start pulse -> busy for 4 cycles, then done=1, quotient=4, remainder=1, dz=0.
REQ-027 The bench SHALL cover: dividend=15, divisor=1 -> quotient=15, remainder=0; and dividend=2, divisor=3 -> quotient=0, remainder=2.
REQ-028 The bench SHALL cover: dividend=9, divisor=0 -> one edge later done=1, dz=1, quotient=15, remainder=1, busy never high.
REQ-029 The bench SHALL cover: start=1 plus new operands (dividend=6, divisor=2) during RUN of 13/3 -> ignored, result is 4 r1; a subsequent start in DONE with 6/2 -> quotient=3, remainder=0.
REQ-030 The bench SHALL cover: rst=1 on the 2nd RUN cycle of 13/3 -> next cycle all outputs 0, state IDLE; a start one cycle later with 10/3 -> quotient=3, remainder=1.
REQ-031 The bench SHALL cover an exhaustive sweep of all 64 dividend/divisor pairs, checked against REQ-018 and REQ-022 with latency exactly 4 edges (1 edge for divisor=0).
